// File: rtl/fir_l2_pkg.sv
// Shared constants and the round/saturate helper for the L=2 FIR output serializer.
package fir_l2_pkg;

    localparam int DATA_WIDTH_DEF = 64;
    localparam int OUT_WIDTH_DEF  = 16;
    localparam int FRAC_SHIFT_DEF = 30;
    localparam int FIFO_DEPTH_DEF = 4;

    // Helper works at a fixed wide width; callers sign-extend in and truncate out.
    localparam int RS_XW = 129;
    localparam int RS_OW = 64;

    typedef enum logic {PH_SLOT1, PH_SLOT2} phase_t;

    typedef struct packed {
        logic             sat;
        logic [RS_OW-1:0] value;
    } rs_t;

    function automatic rs_t round_sat(input logic signed [RS_XW-1:0] x,
                                      input int frac_shift,
                                      input int out_width);
        logic signed [RS_XW-1:0] one, r, s, max_v, min_v;
        rs_t res;
        one = 1;
        r   = x;
        if (frac_shift > 0)
            r = x + (one <<< (frac_shift - 1));
        s     = r >>> frac_shift;
        max_v = (one <<< (out_width - 1)) - one;
        min_v = -max_v - one;
        res.sat = 1'b1;
        if (s > max_v)
            res.value = max_v[RS_OW-1:0];
        else if (s < min_v)
            res.value = min_v[RS_OW-1:0];
        else begin
            res.sat   = 1'b0;
            res.value = s[RS_OW-1:0];
        end
        return res;
    endfunction

endpackage

// File: rtl/fir_pair_fifo.sv
// Synchronous FIFO holding {y(2k+1), y(2k)} pairs with an occupancy count.
module fir_pair_fifo
    import fir_l2_pkg::*;
#(
    parameter int WIDTH = 2 * DATA_WIDTH_DEF,
    parameter int DEPTH = FIFO_DEPTH_DEF,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [AW:0]      count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_wr, do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_wr)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/fir_l2_output_serializer.sv
// 2:1 pair-to-sample serializer: buffers (y(2k), y(2k+1)) pairs, then rounds,
// saturates and emits one sample per cycle on a valid/ready stream.
module fir_l2_output_serializer
    import fir_l2_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF,
    parameter int FRAC_SHIFT = FRAC_SHIFT_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    localparam int LW        = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic signed [DATA_WIDTH-1:0] in_data_1,
    input  logic signed [DATA_WIDTH-1:0] in_data_2,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic signed [OUT_WIDTH-1:0]  out_data,
    output logic                         out_sat,
    output logic [15:0]                  sat_count,
    output logic [LW-1:0]                fill_level
);

    logic [2*DATA_WIDTH-1:0]      head;
    logic signed [DATA_WIDTH-1:0] head_sample;
    logic                         full, empty, load, pop;
    phase_t                       phase;
    rs_t                          rs;

    // in_ready looks only at the registered fill count, never at out_ready.
    assign in_ready = !reset && !full;
    assign load     = (!out_valid || out_ready) && !empty;
    assign pop      = load && (phase == PH_SLOT2);

    fir_pair_fifo #(.WIDTH(2 * DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (in_valid && in_ready),
        .wr_data ({in_data_2, in_data_1}),
        .rd_en   (pop),
        .rd_data (head),
        .count   (fill_level),
        .full    (full),
        .empty   (empty)
    );

    assign head_sample = (phase == PH_SLOT2) ? head[2*DATA_WIDTH-1:DATA_WIDTH]
                                             : head[DATA_WIDTH-1:0];
    assign rs = round_sat(RS_XW'(head_sample), FRAC_SHIFT, OUT_WIDTH);

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
            sat_count <= '0;
            phase     <= PH_SLOT1;
        end else begin
            if (out_valid && out_ready && out_sat && sat_count != 16'hFFFF)
                sat_count <= sat_count + 16'd1;
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= rs.value[OUT_WIDTH-1:0];
                out_sat   <= rs.sat;
                phase     <= (phase == PH_SLOT1) ? PH_SLOT2 : PH_SLOT1;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fir_l2_output_serializer.sv
// Scoreboard bench: accepted pairs push expected samples, a negedge monitor pops on transfer.
module tb_fir_l2_output_serializer;

    logic               clk = 1'b0;
    logic               reset;
    logic               in_valid, in_ready, out_valid, out_ready, out_sat;
    logic signed [63:0] in_data_1, in_data_2;
    logic signed [15:0] out_data;
    logic [15:0]        sat_count;
    logic [2:0]         fill_level;

    int total = 0;
    int bad   = 0;
    logic [16:0] sb[$];

    always #5 clk = ~clk;

    fir_l2_output_serializer #(
        .DATA_WIDTH(64), .OUT_WIDTH(16), .FRAC_SHIFT(30), .FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data_1(in_data_1), .in_data_2(in_data_2), .out_valid(out_valid),
        .out_ready(out_ready), .out_data(out_data), .out_sat(out_sat),
        .sat_count(sat_count), .fill_level(fill_level)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_sample", out_data, 99999);
            end else begin
                logic [16:0] e;
                e = sb.pop_front();
                chk("sample_data", out_data, longint'($signed(e[15:0])));
                chk("sample_sat", out_sat, e[16]);
            end
        end
    end

    // Drive a pair, wait (bounded) for acceptance, push its two expected samples.
    task automatic send(input longint a, input longint b, input int e1, input int e2,
                        input bit s1, input bit s2);
        bit ok = 0;
        in_valid = 1; in_data_1 = a; in_data_2 = b;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({s1, 16'(e1)});
                sb.push_back({s2, 16'(e2)});
                ok = 1;
            end
            @(posedge clk); #1;
        end
        in_valid = 0;
        if (!ok) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        bit ok = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            if (sb.size() == 0 && !out_valid) ok = 1;
        end
        if (!ok) chk("drain_timeout", sb.size(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        int acc;
        reset = 1; in_valid = 0; out_ready = 0; in_data_1 = 0; in_data_2 = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_sat", out_sat, 0);
        chk("rst_sat_count", sat_count, 0);
        chk("rst_fill", fill_level, 0);
        chk("rst_in_ready", in_ready, 0);
        @(posedge clk); #1;
        reset = 0;
        @(posedge clk); #1;

        // 1: latency and order
        out_ready = 1;
        send(64'sd3 <<< 30, -(64'sd5 <<< 30), 3, -5, 0, 0);
        @(negedge clk); chk("t1_valid_t1", out_valid, 0);
        @(negedge clk); chk("t1_valid_t2", out_valid, 1); chk("t1_data_t2", out_data, 3);
        @(negedge clk); chk("t1_valid_t3", out_valid, 1); chk("t1_data_t3", out_data, -5);
        @(negedge clk); chk("t1_valid_t4", out_valid, 0);
        @(posedge clk); #1;

        // 2: round-half-up
        send(64'sd1 <<< 29, (64'sd1 <<< 29) - 1, 1, 0, 0, 0);
        send(-(64'sd1 <<< 29), -(64'sd1 <<< 29) - 1, 0, -1, 0, 0);
        drain();

        // 3: saturation both ways
        send(64'sd40000 <<< 30, -(64'sd40000 <<< 30), 32767, -32768, 1, 1);
        drain();
        chk("t3_sat_count", sat_count, 2);

        // 4: backpressure fills the FIFO, then a gap-free burst
        out_ready = 0; acc = 0; in_valid = 1;
        for (int c = 0; c < 6; c++) begin
            in_data_1 = longint'(acc * 2 + 1) <<< 30;
            in_data_2 = longint'(acc * 2 + 2) <<< 30;
            @(negedge clk);
            if (in_ready) begin
                sb.push_back({1'b0, 16'(acc * 2 + 1)});
                sb.push_back({1'b0, 16'(acc * 2 + 2)});
                acc++;
            end
            @(posedge clk); #1;
        end
        in_valid = 0;
        @(negedge clk);
        chk("t4_accepted", acc, 4);
        chk("t4_in_ready", in_ready, 0);
        chk("t4_fill", fill_level, 4);
        chk("t4_valid_held", out_valid, 1);
        repeat (2) @(negedge clk);
        chk("t4_data_held", out_data, 1);
        @(posedge clk); #1;
        out_ready = 1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk); chk("t4_no_gap", out_valid, 1);
        end
        @(negedge clk); chk("t4_end_valid", out_valid, 0);
        @(posedge clk); #1;

        // 5: one pair every other cycle sustains a continuous stream
        fork
            begin
                for (int p = 0; p < 6; p++) begin
                    send(longint'(11 + 2 * p) <<< 30, longint'(12 + 2 * p) <<< 30,
                         11 + 2 * p, 12 + 2 * p, 0, 0);
                    @(posedge clk); #1;
                end
            end
            begin
                bit seen = 0;
                for (int i = 0; i < 20 && !seen; i++) begin
                    @(negedge clk);
                    if (out_valid) seen = 1;
                end
                if (!seen) chk("t5_first_timeout", 0, 1);
                for (int i = 0; i < 11; i++) begin
                    @(negedge clk);
                    chk("t5_continuous", out_valid, 1);
                    chk("t5_fill_le1", fill_level <= 1, 1);
                end
            end
        join
        drain();

        // 6: mid-stream reset discards buffered and half-emitted pairs
        out_ready = 0;
        send(64'sd20 <<< 30, 64'sd21 <<< 30, 20, 21, 0, 0);
        send(64'sd22 <<< 30, 64'sd23 <<< 30, 22, 23, 0, 0);
        send(64'sd24 <<< 30, 64'sd25 <<< 30, 24, 25, 0, 0);
        @(negedge clk);
        chk("t6_pre_fill", fill_level, 3);
        chk("t6_pre_data", out_data, 20);
        @(posedge clk); #1;
        reset = 1;
        @(negedge clk); chk("t6_in_ready_rst", in_ready, 0);
        @(posedge clk); #1;
        reset = 0;
        sb.delete();
        @(negedge clk);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_fill", fill_level, 0);
        chk("t6_sat_count", sat_count, 0);
        @(posedge clk); #1;
        out_ready = 1;
        send(64'sd7 <<< 30, 64'sd8 <<< 30, 7, 8, 0, 0);
        @(negedge clk);
        @(negedge clk); chk("t6_first_slot1", out_data, 7);
        @(posedge clk); #1;
        drain();
        chk("sb_empty", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
